// File: rtl/note_matrix_scan.sv
// LED matrix consumer: captures loader columns into a scrolling frame buffer and
// scans it out row by row, with tear-free frame update and end-of-song drain.
module note_matrix_scan #(
    parameter int COLS     = 16,
    parameter int ROWS     = 10,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] note_R,
    input  logic [ROWS-1:0] note_G,
    input  logic [3:0]      offset,
    input  logic            finish,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_R,
    output logic [COLS-1:0] col_G,
    output logic            frame_tick,
    output logic            busy
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t state_reg, state_next;

    // Index COLS-1 is the newest column, index 0 the oldest.
    logic [COLS-1:0][ROWS-1:0] shift_r_reg, shift_g_reg;
    logic [COLS-1:0][ROWS-1:0] disp_r_reg, disp_g_reg;

    logic [3:0]      offset_q;
    logic            finish_q;
    logic [RW-1:0]   row_reg;
    logic [DW-1:0]   dwell_reg;
    logic [4:0]      drain_reg, drain_next;
    logic            push, push_zero;
    logic            step, finish_rise, dwell_last, wrap;
    logic [ROWS-1:0] in_r, in_g;
    logic [COLS-1:0] col_r_next, col_g_next;

    assign step        = (offset != offset_q);
    assign finish_rise = finish & ~finish_q;
    assign dwell_last  = (dwell_reg == DW'(SCAN_DIV - 1));
    assign wrap        = dwell_last && (row_reg == RW'(ROWS - 1));
    assign in_r        = push_zero ? '0 : note_R;
    assign in_g        = push_zero ? '0 : note_G;

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        push       = 1'b0;
        push_zero  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (step) begin
                    push       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                push = step;
                if (finish_rise) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                // Flush one blank column per frame until the whole buffer is empty.
                if (wrap) begin
                    push      = 1'b1;
                    push_zero = 1'b1;
                    if (drain_reg == 5'(COLS - 1)) begin
                        state_next = IDLE;
                        drain_next = '0;
                    end else begin
                        drain_next = drain_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            drain_reg <= '0;
            offset_q  <= '0;
            finish_q  <= 1'b1;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            offset_q  <= offset;
            finish_q  <= finish;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_reg <= '0;
            row_reg   <= '0;
        end else if (dwell_last) begin
            dwell_reg <= '0;
            row_reg   <= (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + 1'b1;
        end else begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r_reg <= '0;
            shift_g_reg <= '0;
            disp_r_reg  <= '0;
            disp_g_reg  <= '0;
        end else begin
            if (push) begin
                shift_r_reg <= {in_r, shift_r_reg[COLS-1:1]};
                shift_g_reg <= {in_g, shift_g_reg[COLS-1:1]};
            end
            // Snapshot only at the frame boundary so a frame never mixes scroll positions.
            if (wrap) begin
                disp_r_reg <= shift_r_reg;
                disp_g_reg <= shift_g_reg;
            end
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_r_next[gi] = disp_r_reg[gi][row_reg];
        assign col_g_next[gi] = disp_g_reg[gi][row_reg];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_sel    <= '0;
            col_R      <= '0;
            col_G      <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            row_sel    <= (dwell_reg >= DW'(BLANK) && state_reg != IDLE)
                          ? (ROWS'(1) << row_reg) : '0;
            col_R      <= col_r_next;
            col_G      <= col_g_next;
            frame_tick <= wrap;
            busy       <= (state_next != IDLE);
        end
    end
endmodule

// File: tb/tb_note_matrix_scan.sv
// Bench for note_matrix_scan: directed vector table, corner sequences, and random
// traffic compared every cycle against a queue-based reference model.
module tb_note_matrix_scan;
    localparam int COLS  = 16;
    localparam int ROWS  = 10;
    localparam int SD    = 4;
    localparam int BL    = 1;
    localparam int FRAME = ROWS * SD;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ROWS-1:0] note_r_in, note_g_in;
    logic [3:0]      offset_in;
    logic            finish_in;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_r, col_g;
    logic            frame_tick, busy;

    note_matrix_scan #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk(clk), .rst(rst_n), .note_R(note_r_in), .note_G(note_g_in),
        .offset(offset_in), .finish(finish_in), .row_sel(row_sel),
        .col_R(col_r), .col_G(col_g), .frame_tick(frame_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state: scan position within the frame, queue of columns (front = oldest).
    int              pos, mode, drains;
    logic [3:0]      m_off_q;
    logic            m_fin_q;
    logic [ROWS-1:0] sh_r[$], sh_g[$];
    logic [ROWS-1:0] dp_r[COLS], dp_g[COLS];
    logic [ROWS-1:0] exp_row_sel;
    logic [COLS-1:0] exp_col_r, exp_col_g;
    logic            exp_tick, exp_busy;
    int              n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [ROWS-1:0] r;
        logic [ROWS-1:0] g;
        int              row;
        logic [COLS-1:0] exp_r;
        logic [COLS-1:0] exp_g;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        pos = 0; mode = M_IDLE; drains = 0; m_off_q = '0; m_fin_q = 1'b1;
        sh_r.delete(); sh_g.delete();
        for (int c = 0; c < COLS; c++) begin
            sh_r.push_back('0); sh_g.push_back('0);
            dp_r[c] = '0; dp_g[c] = '0;
        end
        exp_row_sel = '0; exp_col_r = '0; exp_col_g = '0; exp_tick = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic model_push(input logic [ROWS-1:0] r, input logic [ROWS-1:0] g);
        void'(sh_r.pop_front()); void'(sh_g.pop_front());
        sh_r.push_back(r); sh_g.push_back(g);
    endtask

    task automatic model_step();
        int   row, dw;
        logic wrap, stp, rise;
        row  = pos / SD;
        dw   = pos % SD;
        wrap = (pos == FRAME - 1);
        stp  = (offset_in != m_off_q);
        rise = finish_in && !m_fin_q;
        exp_row_sel = (dw >= BL && mode != M_IDLE) ? (ROWS'(1) << row) : '0;
        for (int c = 0; c < COLS; c++) begin
            exp_col_r[c] = dp_r[c][row];
            exp_col_g[c] = dp_g[c][row];
        end
        exp_tick = wrap;
        if (wrap)
            for (int c = 0; c < COLS; c++) begin
                dp_r[c] = sh_r[c]; dp_g[c] = sh_g[c];
            end
        case (mode)
            M_IDLE: if (stp) begin model_push(note_r_in, note_g_in); mode = M_RUN; end
            M_RUN: begin
                if (stp) model_push(note_r_in, note_g_in);
                if (rise) begin mode = M_DRAIN; drains = 0; end
            end
            default: if (wrap) begin
                model_push('0, '0);
                drains++;
                if (drains == COLS) mode = M_IDLE;
            end
        endcase
        exp_busy = (mode != M_IDLE);
        pos      = (pos + 1) % FRAME;
        m_off_q  = offset_in;
        m_fin_q  = finish_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("row_sel", 32'(row_sel), 32'(exp_row_sel));
        chk("col_R", 32'(col_r), 32'(exp_col_r));
        chk("col_G", 32'(col_g), 32'(exp_col_g));
        chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic push_col(input logic [ROWS-1:0] r, input logic [ROWS-1:0] g);
        note_r_in = r;
        note_g_in = g;
        offset_in = offset_in + 4'd1;
        tick();
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin tick(); n++; end while (!frame_tick && n < 2 * FRAME + 4);
        if (!frame_tick) timeout("wait_frame_tick");
    endtask

    task automatic wait_row(input int r);
        logic [ROWS-1:0] tgt;
        int n = 0;
        tgt = ROWS'(1) << r;
        do begin tick(); n++; end while (row_sel !== tgt && n < 2 * FRAME);
        if (row_sel !== tgt) timeout("wait_row");
    endtask

    task automatic quick_reset();
        rst_n = 1'b0;
        tick(); tick();
        offset_in = '0;
        finish_in = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int n, seen;
        logic lit;
        vecs[0] = '{10'h001, 10'h000, 0, 16'h8000, 16'h0000};
        vecs[1] = '{10'h000, 10'h008, 3, 16'h0000, 16'h8000};
        vecs[2] = '{10'h009, 10'h000, 0, 16'hA000, 16'h0000};
        vecs[3] = '{10'h000, 10'h200, 9, 16'h0000, 16'h8000};
        vecs[4] = '{10'h3FF, 10'h3FF, 3, 16'hA000, 16'h9000};

        // Reset with random inputs, then time to first frame_tick.
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            note_r_in = 10'($urandom); note_g_in = 10'($urandom);
            offset_in = 4'($urandom);  finish_in = 1'($urandom);
            tick();
        end
        offset_in = '0;
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!frame_tick && n < 100);
        chk("first_tick_delay", 32'(n), 32'(FRAME));
        finish_in = 1'b0;
        tick();

        // Vector table: push one column, check a chosen row in the next frame.
        for (int i = 0; i < 5; i++) begin
            push_col(vecs[i].r, vecs[i].g);
            if (i == 0) chk("busy_after_push", 32'(busy), 32'd1);
            wait_frame();
            wait_row(vecs[i].row);
            chk("vec_col_R", 32'(col_r), 32'(vecs[i].exp_r));
            chk("vec_col_G", 32'(col_g), 32'(vecs[i].exp_g));
        end

        // Scroll: oldest column reaches column 0, then falls off.
        quick_reset();
        push_col(10'h001, 10'h000);
        for (int i = 0; i < COLS - 1; i++) push_col(10'h000, 10'h000);
        wait_frame();
        wait_row(0);
        chk("scroll_col0", 32'(col_r), 32'h0001);
        push_col(10'h000, 10'h000);
        wait_frame();
        wait_row(0);
        chk("scroll_drop", 32'(col_r), 32'h0000);

        // Tear-free: a mid-frame push must not show until the next frame.
        wait_row(4);
        push_col(10'h3FF, 10'h000);
        wait_row(9);
        chk("tear_hold", 32'(col_r), 32'h0000);
        wait_frame();
        wait_row(9);
        chk("tear_update", 32'(col_r), 32'h8000);

        // Drain: finish rises with a push; further steps ignored; 16 frames to idle.
        finish_in = 1'b1;
        push_col(10'h001, 10'h000);
        chk("drain_busy_start", 32'(busy), 32'd1);
        push_col(10'h3FF, 10'h3FF);
        seen = frame_tick ? 1 : 0;
        while (seen < COLS) begin
            if (seen == COLS - 1) chk("drain_busy_15", 32'(busy), 32'd1);
            wait_frame();
            seen++;
        end
        chk("drain_busy_end", 32'(busy), 32'd0);
        lit = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (row_sel != '0) lit = 1'b1;
        end
        chk("drain_dark", 32'(lit), 32'd0);

        // Reset mid-drain goes dark at once; finish held high after release is not an edge.
        finish_in = 1'b0;
        tick();
        push_col(10'h001, 10'h000);
        finish_in = 1'b1;
        tick();
        wait_row(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_row_sel", 32'(row_sel), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_col_R", 32'(col_r), 32'd0);
        repeat (3) tick();
        offset_in = '0;
        rst_n = 1'b1;
        push_col(10'h002, 10'h000);
        repeat (60) tick();
        chk("no_drain_after_reset", 32'(busy), 32'd1);

        // Random traffic against the model.
        quick_reset();
        for (int i = 0; i < 3000; i++) begin
            note_r_in = 10'($urandom);
            note_g_in = 10'($urandom);
            if ($urandom_range(0, 3) == 0) offset_in = 4'($urandom);
            if ($urandom_range(0, 40) == 0) finish_in = ~finish_in;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/note_matrix_scan.md
# note_matrix_scan

Consumer end of the note-load interface. It captures the note columns produced by the song loader (`note_R`, `note_G`, `offset`, `finish`) into a scrolling 16-column frame buffer. It then time-multiplexes that buffer onto the LED matrix as row-select plus red/green column drive. It sits between the song loader and the matrix pins, and owns scroll history, tear-free frame update and end-of-song drain.

## Interface
- `COLS`, 16, number of matrix columns (buffer depth in columns)
- `ROWS`, 10, number of matrix rows (width of `note_R`/`note_G`)
- `SCAN_DIV`, 1000, clock cycles each row is held (dwell); must be > `BLANK`
- `BLANK`, 8, cycles at the start of each dwell with all rows off (ghost suppression)
- `clk`  input  1  system clock
- `rst`  input  1  reset, asynchronous, active-low
- `note_R`  input  ROWS  red note bits of the incoming column, bit r = row r
- `note_G`  input  ROWS  green note bits of the incoming column
- `offset`  input  4  loader step counter; any change of value marks one new column
- `finish`  input  1  loader end-of-song flag, level
- `row_sel`  output  ROWS  one-hot active-high row enable, all-zero when blanked or idle
- `col_R`  output  COLS  red column drive for the selected row, bit c = column c
- `col_G`  output  COLS  green column drive for the selected row
- `frame_tick`  output  1  one-cycle pulse when the scan wraps from row ROWS-1 to row 0
- `busy`  output  1  high in RUN and DRAIN

## Operation
- Shift buffer: COLS entries of {R[ROWS], G[ROWS]}.
  - Column 0 holds the oldest entry; column COLS-1 holds the newest.
  - A push moves every entry down one index, drops column 0, and writes {note_R, note_G} (or zeros in DRAIN) into COLS-1.
- Display buffer: a copy of the shift buffer.
  - Loaded only in the cycle `frame_tick` is asserted, so a frame never mixes two scroll positions.
- Push detect: `offset_q` is `offset` registered every cycle. The condition `offset != offset_q` gives one push, with the data sampled in that same cycle.
- FSM states IDLE, RUN, DRAIN.
  - IDLE: the scan counters run, `row_sel` is forced to 0 and `busy` is 0.
    - IDLE -> RUN on the first push; that push is performed.
  - RUN: pushes are performed. RUN -> DRAIN on the rising edge of `finish` (`finish` & ~`finish_q`).
    - If a push and the `finish` rise occur in the same cycle, the column is pushed first and the state still goes to DRAIN.
  - DRAIN: `offset` changes are ignored.
    - One zero column is pushed on each `frame_tick`. A 5-bit drain counter counts these.
    - After COLS zero pushes, DRAIN -> IDLE. The shift buffer is then all-zero.
  - A `finish` rise while in IDLE or DRAIN is ignored.
  - A `finish` held high does not retrigger.
- Scan:
  - `row_ctr` counts 0..ROWS-1.
  - `dwell_ctr` counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and `row_ctr` advances.
  - `row_ctr` wraps ROWS-1 -> 0, and `frame_tick` pulses in that wrap cycle.
- Outputs (all registered):
  - `row_sel` = onehot(`row_ctr`) when `dwell_ctr` >= `BLANK` and state != IDLE, else 0.
  - `col_R[c]` = display[c].R[row_ctr] and `col_G[c]` = display[c].G[row_ctr]. These are driven even while blanked.

## Timing
- Reset (async assert, synchronous release) clears:
  - both buffers and `offset_q`
  - `row_ctr`, `dwell_ctr` and the drain counter
  - the state, to IDLE
  - all outputs: `row_sel`=0, `col_R`=`col_G`=0, `frame_tick`=0, `busy`=0.
- `finish_q` is reset to 1. A `finish` already high at release is therefore not an edge.
- Reset asserted mid-RUN or mid-DRAIN aborts immediately, and the matrix goes dark on assertion.
- Push latency: the entry is in the shift buffer 1 cycle after the `offset` change. It reaches the display at the next `frame_tick` and appears on `col_R`/`col_G` 1 cycle after that.
- `busy` rises the cycle after the first push is detected and falls the cycle after the last drain push.
- `frame_tick` period is exactly ROWS*SCAN_DIV cycles, starting ROWS*SCAN_DIV cycles after reset release.
- Back-to-back `offset` changes on consecutive cycles each push; no push is lost.

## Test plan
All scenarios use `SCAN_DIV`=4, `BLANK`=1.

- Reset: hold `rst`=0 with random inputs -> all outputs 0. Release -> `frame_tick` first pulses 40 cycles later, and `row_sel` stays 0 while IDLE.
- Single push: `note_R`=10'b0000000001, `note_G`=0, step `offset` 0->1 -> `busy`=1, and after the next `frame_tick`, when `row_sel`=10'b1, `col_R`=16'h8000 and `col_G`=0.
- Scroll: push 16 columns, only the first with R bit 0 set -> after 16 pushes and a `frame_tick`, row 0 shows `col_R`=16'h0001; one more push of zeros -> `col_R`=0.
- Tear-free: change `offset` mid-frame -> `col_R`/`col_G` stay constant across all 10 rows of that frame and update only after `frame_tick`.
- Drain: `finish` rises together with an `offset` step -> that column is pushed, state goes to DRAIN, a further `offset` step is ignored, and after 16 `frame_tick`s `busy`=0 and `row_sel`=0.
- Reset mid-DRAIN: assert `rst` during DRAIN -> `row_sel`=0 in the same cycle. After release, `finish` held high causes no DRAIN.
